// File: rtl/rx_majority_sampler.sv
// Purpose: oversampled UART RX bit sampler; majority vote of 1/3/5 samples centred in each bit.
// Latency: sample_valid rises on the clk edge after the edge that captures the last window slot.
// Backpressure: none; one strobe per window, data_sampling_en=0 aborts a partial window.
module rx_majority_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int MAX_VOTES  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            vote_mode,
    input  logic                  data_sampling_en,
    input  logic [PRESCALE_W-1:0] edge_count,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_flag
);

    // CW holds a vote count 0..MAX_VOTES, SW indexes a slot 0..MAX_VOTES-1
    localparam int CW = $clog2(MAX_VOTES + 1);
    localparam int SW = $clog2(MAX_VOTES);

    logic [PRESCALE_W-1:0] eff_prescale_q, eff_prescale_d;
    logic [CW-1:0]         eff_votes_q, eff_votes_d;
    logic [MAX_VOTES-1:0]  store_q, store_d;
    logic [MAX_VOTES-1:0]  capt_q, capt_d;
    logic                  fire_q, fire_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  sample_valid_q;
    logic                  noise_flag_q, noise_flag_d;

    logic [CW-1:0]         req_votes;
    logic [CW-1:0]         votes_m1;
    logic [PRESCALE_W-1:0] centre, half, win_lo, win_hi;
    logic                  in_win;
    logic [SW-1:0]         slot_idx, final_idx;
    logic [MAX_VOTES-1:0]  capt_base;
    logic                  capt_hit;
    logic [CW-1:0]         ones_cnt, capt_cnt;
    logic                  vote_bit, vote_noise;

    // Configuration tracks the inputs while idle and freezes for the whole time sampling is enabled;
    // demotion keeps the window inside the bit period for small prescale values
    always_comb begin
        case (vote_mode)
            2'b00:   req_votes = CW'(1);
            2'b10:   req_votes = CW'(5);
            default: req_votes = CW'(3);
        endcase
        eff_votes_d = req_votes;
        if (eff_votes_d == CW'(5) && prescale < PRESCALE_W'(8)) eff_votes_d = CW'(3);
        if (eff_votes_d == CW'(3) && prescale < PRESCALE_W'(4)) eff_votes_d = CW'(1);
        eff_prescale_d = prescale;
        if (data_sampling_en) begin
            eff_votes_d    = eff_votes_q;
            eff_prescale_d = eff_prescale_q;
        end
    end

    // Window geometry: slots C-h..C+h around the truncated bit centre, never past the bit end
    always_comb begin
        votes_m1  = eff_votes_q - CW'(1);
        centre    = eff_prescale_q >> 1;
        half      = PRESCALE_W'(votes_m1 >> 1);
        win_lo    = centre - half;
        win_hi    = centre + half;
        in_win    = (edge_count >= win_lo) && (edge_count <= win_hi) &&
                    (edge_count < eff_prescale_q);
        slot_idx  = SW'(edge_count - win_lo);
        final_idx = SW'(votes_m1);
        // edge_count=0 opens a new window, so captured bits are treated as already clear
        capt_base = (edge_count == '0) ? '0 : capt_q;
        capt_hit  = data_sampling_en && in_win && !capt_base[slot_idx];
    end

    // Sample store update: first capture per slot wins; disabling sampling drops the window
    always_comb begin
        capt_d  = capt_q;
        store_d = store_q;
        fire_d  = 1'b0;
        if (!data_sampling_en) begin
            capt_d  = '0;
            store_d = '0;
        end else begin
            capt_d = capt_base;
            if (capt_hit) begin
                capt_d[slot_idx]  = 1'b1;
                store_d[slot_idx] = RX_in;
                fire_d            = (slot_idx == final_idx);
            end
        end
    end

    // Vote over captured slots only; a short window or any disagreement raises noise
    always_comb begin
        ones_cnt = '0;
        capt_cnt = '0;
        for (int i = 0; i < MAX_VOTES; i++) begin
            ones_cnt = ones_cnt + CW'(store_q[i] & capt_q[i]);
            capt_cnt = capt_cnt + CW'(capt_q[i]);
        end
        vote_bit   = {ones_cnt, 1'b0} > {1'b0, capt_cnt};
        vote_noise = (capt_cnt != eff_votes_q) ||
                     ((ones_cnt != '0) && (ones_cnt != capt_cnt));
        sampled_bit_d = sampled_bit_q;
        noise_flag_d  = noise_flag_q;
        if (fire_q) begin
            sampled_bit_d = vote_bit;
            noise_flag_d  = vote_noise;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            eff_prescale_q <= PRESCALE_W'(8);
            eff_votes_q    <= CW'(3);
            store_q        <= '0;
            capt_q         <= '0;
            fire_q         <= 1'b0;
            sampled_bit_q  <= 1'b0;
            sample_valid_q <= 1'b0;
            noise_flag_q   <= 1'b0;
        end else begin
            eff_prescale_q <= eff_prescale_d;
            eff_votes_q    <= eff_votes_d;
            store_q        <= store_d;
            capt_q         <= capt_d;
            fire_q         <= fire_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= fire_q;
            noise_flag_q   <= noise_flag_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign noise_flag   = noise_flag_q;

endmodule

// File: tb/tb_rx_majority_sampler.sv
// Purpose: directed self-checking bench for rx_majority_sampler.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable; stimulus is one edge_count step per clock.
module tb_rx_majority_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_in = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [1:0] vote_mode = 2'b01;
    logic       data_sampling_en = 1'b0;
    logic [5:0] edge_count = 6'd0;
    logic       sampled_bit, sample_valid, noise_flag;

    int vectors = 0;
    int miscompares = 0;
    int sv_cnt, sv_at, step_idx;
    logic sb_seen, nf_seen;

    rx_majority_sampler #(.PRESCALE_W(6), .MAX_VOTES(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .RX_in            (RX_in),
        .prescale         (prescale),
        .vote_mode        (vote_mode),
        .data_sampling_en (data_sampling_en),
        .edge_count       (edge_count),
        .sampled_bit      (sampled_bit),
        .sample_valid     (sample_valid),
        .noise_flag       (noise_flag)
    );

    always #5 clk = ~clk;

    task automatic clear_obs();
        sv_cnt = 0; sv_at = -1; step_idx = 0; sb_seen = 1'bx; nf_seen = 1'bx;
    endtask

    // one clock of stimulus, then record any strobe seen after the edge
    task automatic step(input int e, input logic r, input logic en_v);
        edge_count = 6'(e); RX_in = r; data_sampling_en = en_v;
        @(posedge clk); #1;
        if (sample_valid === 1'b1) begin
            sv_cnt++; sv_at = step_idx; sb_seen = sampled_bit; nf_seen = noise_flag;
        end
        step_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0);
    endtask

    // one full bit (edge_count 0..ps-1) plus the first cycle of the next bit
    task automatic run_bit(input int ps, input logic [31:0] rx);
        clear_obs();
        for (int i = 0; i < ps; i++) step(i, rx[i], 1'b1);
        step(0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        prescale = 6'd16; vote_mode = 2'b10; rst = 1'b0;
        step(3, 1'b1, 1'b1);
        step(3, 1'b1, 1'b1);
        vectors++; if (sampled_bit !== 1'b0) begin miscompares++; $display("FAIL reset_sb got %b want 0", sampled_bit); end
        vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sv got %b want 0", sample_valid); end
        vectors++; if (noise_flag !== 1'b0) begin miscompares++; $display("FAIL reset_nf got %b want 0", noise_flag); end
        // enable held through release: reset defaults 8/3 stay in force
        rst = 1'b1;
        run_bit(8, 32'h18);
        vectors++; if (sv_cnt !== 1 || sv_at !== 6) begin miscompares++; $display("FAIL reset_cfg_strobe got cnt=%0d at=%0d want 1 at 6", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_vote got sb=%b nf=%b want 1 1", sb_seen, nf_seen); end
    endtask

    task automatic test_three_vote();
        prescale = 6'd8; vote_mode = 2'b01; idle(1);
        run_bit(8, 32'h18);
        vectors++; if (sv_cnt !== 1 || sv_at !== 6) begin miscompares++; $display("FAIL v3_strobe got cnt=%0d at=%0d want 1 at 6", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL v3_vote got sb=%b nf=%b want 1 1", sb_seen, nf_seen); end
        vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL v3_after got sv=%b want 0", sample_valid); end
    endtask

    task automatic test_five_vote();
        prescale = 6'd16; vote_mode = 2'b10; idle(1);
        run_bit(16, 32'h0300);
        vectors++; if (sv_cnt !== 1 || sv_at !== 11) begin miscompares++; $display("FAIL v5a_strobe got cnt=%0d at=%0d want 1 at 11", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b0 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL v5a_vote got sb=%b nf=%b want 0 1", sb_seen, nf_seen); end
        run_bit(16, 32'hFFFF);
        vectors++; if (sv_cnt !== 1 || sv_at !== 11) begin miscompares++; $display("FAIL v5b_strobe got cnt=%0d at=%0d want 1 at 11", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL v5b_vote got sb=%b nf=%b want 1 0", sb_seen, nf_seen); end
    endtask

    task automatic test_demote();
        prescale = 6'd4; vote_mode = 2'b10; idle(1);
        run_bit(4, 32'hA);
        vectors++; if (sv_cnt !== 1 || sv_at !== 4) begin miscompares++; $display("FAIL dem4_strobe got cnt=%0d at=%0d want 1 at 4", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL dem4_vote got sb=%b nf=%b want 1 1", sb_seen, nf_seen); end
        prescale = 6'd2; vote_mode = 2'b01; idle(1);
        run_bit(2, 32'h2);
        vectors++; if (sv_cnt !== 1 || sv_at !== 2) begin miscompares++; $display("FAIL dem2a_strobe got cnt=%0d at=%0d want 1 at 2", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL dem2a_vote got sb=%b nf=%b want 1 0", sb_seen, nf_seen); end
        run_bit(2, 32'h1);
        vectors++; if (sb_seen !== 1'b0 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL dem2b_vote got sb=%b nf=%b want 0 0", sb_seen, nf_seen); end
    endtask

    task automatic test_abort();
        prescale = 6'd8; vote_mode = 2'b01; idle(1);
        run_bit(8, 32'hFF);
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL abort_pre got sb=%b nf=%b want 1 0", sb_seen, nf_seen); end
        clear_obs();
        for (int i = 0; i < 4; i++) step(i, 1'b0, 1'b1);
        for (int i = 4; i < 8; i++) step(i, 1'b0, 1'b0);
        vectors++; if (sv_cnt !== 0) begin miscompares++; $display("FAIL abort_strobe got cnt=%0d want 0", sv_cnt); end
        vectors++; if (sampled_bit !== 1'b1 || noise_flag !== 1'b0) begin miscompares++; $display("FAIL abort_hold got sb=%b nf=%b want 1 0", sampled_bit, noise_flag); end
    endtask

    task automatic test_repeat_and_reset();
        prescale = 6'd8; vote_mode = 2'b01; idle(1);
        clear_obs();
        step(0, 1'b1, 1'b1); step(1, 1'b1, 1'b1); step(2, 1'b1, 1'b1);
        step(3, 1'b0, 1'b1); step(4, 1'b0, 1'b1);
        step(5, 1'b0, 1'b1); step(5, 1'b1, 1'b1); step(5, 1'b1, 1'b1);
        step(6, 1'b1, 1'b1); step(7, 1'b1, 1'b1); step(0, 1'b0, 1'b1);
        vectors++; if (sv_cnt !== 1 || sv_at !== 6) begin miscompares++; $display("FAIL repeat_strobe got cnt=%0d at=%0d want 1 at 6", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b0 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL repeat_vote got sb=%b nf=%b want 0 0", sb_seen, nf_seen); end
        run_bit(8, 32'h18);
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got sb=%b nf=%b want 1 1", sb_seen, nf_seen); end
        clear_obs();
        for (int i = 1; i < 5; i++) step(i, 1'b1, 1'b1);
        rst = 1'b0;
        step(5, 1'b1, 1'b1);
        vectors++; if ({sampled_bit, sample_valid, noise_flag} !== 3'b000) begin miscompares++; $display("FAIL midrst_out got sb/sv/nf=%b want 000", {sampled_bit, sample_valid, noise_flag}); end
        rst = 1'b1;
        step(6, 1'b1, 1'b1); step(7, 1'b1, 1'b1);
        vectors++; if (sv_cnt !== 0) begin miscompares++; $display("FAIL midrst_strobe got cnt=%0d want 0", sv_cnt); end
    endtask

    task automatic test_missing();
        prescale = 6'd8; vote_mode = 2'b01; idle(1);
        clear_obs();
        step(0, 1'b0, 1'b1); step(1, 1'b0, 1'b1); step(2, 1'b0, 1'b1);
        step(5, 1'b1, 1'b1); step(6, 1'b0, 1'b1); step(7, 1'b0, 1'b1);
        vectors++; if (sv_cnt !== 1 || sv_at !== 4) begin miscompares++; $display("FAIL miss1_strobe got cnt=%0d at=%0d want 1 at 4", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL miss1_vote got sb=%b nf=%b want 1 1", sb_seen, nf_seen); end
        clear_obs();
        step(0, 1'b0, 1'b1); step(1, 1'b0, 1'b1); step(3, 1'b1, 1'b1);
        step(5, 1'b0, 1'b1); step(6, 1'b0, 1'b1); step(7, 1'b0, 1'b1);
        vectors++; if (sv_cnt !== 1 || sb_seen !== 1'b0 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL miss2_tie got cnt=%0d sb=%b nf=%b want 1 0 1", sv_cnt, sb_seen, nf_seen); end
    endtask

    task automatic test_odd_prescale();
        prescale = 6'd9; vote_mode = 2'b01; idle(1);
        run_bit(9, 32'h1C7);
        vectors++; if (sv_cnt !== 1 || sv_at !== 6) begin miscompares++; $display("FAIL odd_strobe got cnt=%0d at=%0d want 1 at 6", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b0 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL odd_vote got sb=%b nf=%b want 0 0", sb_seen, nf_seen); end
    endtask

    task automatic test_mode_freeze();
        prescale = 6'd16; vote_mode = 2'b01; idle(1);
        vote_mode = 2'b10;
        run_bit(16, 32'h0380);
        vectors++; if (sv_cnt !== 1 || sv_at !== 10) begin miscompares++; $display("FAIL freeze_strobe got cnt=%0d at=%0d want 1 at 10", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b0) begin miscompares++; $display("FAIL freeze_vote got sb=%b nf=%b want 1 0", sb_seen, nf_seen); end
        idle(1);
        run_bit(16, 32'h0380);
        vectors++; if (sv_cnt !== 1 || sv_at !== 11) begin miscompares++; $display("FAIL reload_strobe got cnt=%0d at=%0d want 1 at 11", sv_cnt, sv_at); end
        vectors++; if (sb_seen !== 1'b1 || nf_seen !== 1'b1) begin miscompares++; $display("FAIL reload_vote got sb=%b nf=%b want 1 1", sb_seen, nf_seen); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_three_vote();
        test_five_vote();
        test_demote();
        test_abort();
        test_repeat_and_reset();
        test_missing();
        test_odd_prescale();
        test_mode_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
